// File: rtl/pixel_scanner.sv
// Per-angle frame sequencer: walks every (row, color) of one angle,
// reads the frame RAM and streams the pixels to the serializer.
module pixel_scanner #(
    parameter int NB_ROWS = 32,
    parameter int NB_ANGLES = 128,
    parameter int DATA_WIDTH = 8,
    localparam int ROW_WIDTH = $clog2(NB_ROWS),
    localparam int ANGLE_WIDTH = $clog2(NB_ANGLES)
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   angle_tick,
    input  logic [ANGLE_WIDTH-1:0] new_angle,
    output logic [ROW_WIDTH-1:0]   row,
    output logic [ANGLE_WIDTH-1:0] angle,
    output logic [1:0]             color,
    output logic                   rd_en,
    input  logic [DATA_WIDTH-1:0]  r_data,
    output logic [DATA_WIDTH-1:0]  pix_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   pix_last,
    output logic                   busy,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [ROW_WIDTH-1:0] ROW_MAX = ROW_WIDTH'(NB_ROWS - 1);
    localparam logic [1:0] COLOR_MAX = 2'd2;

    state_t state_q, state_d;

    logic [ROW_WIDTH-1:0]   row_q, row_d;
    logic [1:0]             color_q, color_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;

    logic                   pend_q, pend_d;
    logic [ANGLE_WIDTH-1:0] pend_angle_q, pend_angle_d;
    logic                   ovr_q, ovr_d;

    logic                   infl_q;
    logic                   infl_last_q;

    logic [DATA_WIDTH-1:0]  fifo_data [2];
    logic                   fifo_last [2];
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             cnt_q;

    logic                   issue;
    logic                   start;
    logic                   is_last;
    logic                   pop;
    logic                   push;
    logic                   done;
    logic                   can_issue;
    logic                   store;
    logic                   consume;
    logic [1:0]             occ;
    logic [ANGLE_WIDTH-1:0] start_angle;

    assign is_last   = (row_q == ROW_MAX) && (color_q == COLOR_MAX);
    assign push      = infl_q;
    assign pix_valid = (cnt_q != 2'd0);
    assign pix_data  = fifo_data[rd_ptr_q];
    assign pix_last  = pix_valid & fifo_last[rd_ptr_q];
    assign pop       = pix_valid & pix_ready;
    assign done      = pop & pix_last;

    // Words already buffered plus the one that may still be returning
    // from the RAM; the FIFO can never be asked to hold more than two.
    assign occ       = cnt_q + {1'b0, infl_q};
    assign can_issue = (occ < 2'd2) || ((occ == 2'd2) && pop);

    // Pending slot is preferred over a fresh tick: it is older.
    assign start_angle = pend_q ? pend_angle_q : new_angle;

    assign rd_en   = issue;
    assign row     = row_q;
    assign color   = color_q;
    assign angle   = angle_q;
    assign busy    = (state_q != IDLE);
    assign overrun = ovr_q;

    // Sequencer next state and issue counters.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        color_d = color_q;
        angle_d = angle_q;
        issue   = 1'b0;
        start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (angle_tick || pend_q) begin
                    start = 1'b1;
                end
            end
            SCAN: begin
                if (can_issue) begin
                    issue = 1'b1;
                    if (is_last) begin
                        state_d = DRAIN;
                    end else if (color_q == COLOR_MAX) begin
                        color_d = 2'd0;
                        row_d   = row_q + ROW_WIDTH'(1);
                    end else begin
                        color_d = color_q + 2'd1;
                    end
                end
            end
            DRAIN: begin
                if (done) begin
                    if (pend_q) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start) begin
            state_d = SCAN;
            row_d   = '0;
            color_d = 2'd0;
            angle_d = start_angle;
        end
    end

    // Pending-tick slot: a tick is parked unless it starts a scan at once.
    always_comb begin
        consume      = start & pend_q;
        store        = angle_tick & ~((state_q == IDLE) & ~pend_q);
        pend_d       = store | (pend_q & ~consume);
        pend_angle_d = store ? new_angle : pend_angle_q;
        ovr_d        = store & pend_q & ~consume;
    end

    // Sequencer, address and pending registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            row_q        <= '0;
            color_q      <= 2'd0;
            angle_q      <= '0;
            pend_q       <= 1'b0;
            pend_angle_q <= '0;
            ovr_q        <= 1'b0;
            infl_q       <= 1'b0;
            infl_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            color_q      <= color_d;
            angle_q      <= angle_d;
            pend_q       <= pend_d;
            pend_angle_q <= pend_angle_d;
            ovr_q        <= ovr_d;
            infl_q       <= issue;
            infl_last_q  <= issue & is_last;
        end
    end

    // Two-entry output FIFO; captures the RAM word one cycle after rd_en.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= r_data;
                fifo_last[wr_ptr_q] <= infl_last_q;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_scanner.sv
// Randomised scoreboard bench for pixel_scanner with a frame RAM model
// and a scan-level reference of tick/pending behaviour.
module tb_pixel_scanner;

    localparam int NR = 32;
    localparam int NA = 128;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       angle_tick = 1'b0;
    logic [6:0] new_angle = '0;
    logic [4:0] row;
    logic [6:0] angle;
    logic [1:0] color;
    logic       rd_en;
    logic [7:0] r_data;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready = 1'b0;
    logic       pix_last;
    logic       busy;
    logic       overrun;

    pixel_scanner dut (
        .clk        (clk),
        .nrst       (nrst),
        .angle_tick (angle_tick),
        .new_angle  (new_angle),
        .row        (row),
        .angle      (angle),
        .color      (color),
        .rd_en      (rd_en),
        .r_data     (r_data),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       l;
        logic [7:0] d;
    } exp_t;

    logic [7:0] mem [NA][NR][3];
    exp_t       exp_q [$];

    int vectors = 0;
    int miscompares = 0;
    int reads = 0;
    int pops = 0;
    int ovr_seen = 0;
    int exp_ovr = 0;
    bit m_busy = 0;
    bit m_pend = 0;
    int m_pend_a = 0;
    bit prev_stall = 0;
    logic [7:0] prev_d = '0;
    logic prev_l = 1'b0;

    // Frame RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            r_data <= (color < 2'd3) ? mem[angle][row][color] : 8'h00;
        end
    end

    function automatic void check(input string name, input int act,
                                  input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void push_scan(input int a);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp_t e;
                e.d = mem[a][r][c];
                e.l = (r == NR - 1) && (c == 2);
                exp_q.push_back(e);
            end
        end
    endfunction

    // Monitor: scoreboard pops, stall stability, read occupancy.
    always @(negedge clk) begin
        if (nrst) begin
            automatic bit   pop = pix_valid && pix_ready;
            automatic int   occ = reads - pops;
            automatic exp_t e;
            if (rd_en) begin
                check("rd_color_lt3", int'(color < 2'd3), 1);
                check("rd_when_full", int'((occ - int'(pop)) >= 2), 0);
            end
            if (prev_stall) begin
                check("stall_valid", int'(pix_valid), 1);
                check("stall_data", int'({prev_l, prev_d}),
                      int'({pix_last, pix_data}));
            end
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pix_data", int'(pix_data), int'(e.d));
                    check("pix_last", int'(pix_last), int'(e.l));
                    if (e.l) begin
                        if (m_pend) begin
                            push_scan(m_pend_a);
                            m_pend = 0;
                        end else begin
                            m_busy = 0;
                        end
                    end
                end
            end
            if (overrun) ovr_seen++;
            prev_stall = pix_valid && !pix_ready;
            prev_d = pix_data;
            prev_l = pix_last;
            if (rd_en) reads++;
            if (pop) pops++;
        end
    end

    task automatic do_tick(input int a);
        angle_tick = 1'b1;
        new_angle = 7'(a);
        if (!m_busy) begin
            push_scan(a);
            m_busy = 1;
        end else begin
            if (m_pend) exp_ovr++;
            m_pend = 1;
            m_pend_a = a;
        end
        @(posedge clk);
        #1;
        angle_tick = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input int budget);
        int n = 0;
        while ((m_busy || exp_q.size() != 0 || busy) && n < budget) begin
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", int'(n < budget), 1);
        pix_ready = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_valid"}, int'(pix_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_addr"}, int'({row, angle, color}), 0);
        check({tag, "_data"}, int'({pix_last, pix_data}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int gaps;
        int n;
        int bad;

        for (int a = 0; a < NA; a++)
            for (int r = 0; r < NR; r++)
                for (int c = 0; c < 3; c++)
                    mem[a][r][c] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Single scan, angle 5, sink always ready.
        pix_ready = 1'b1;
        base = reads;
        do_tick(5);
        check("first_rd", int'({rd_en, row, angle, color}),
              int'({1'b1, 5'd0, 7'd5, 2'd0}));
        @(posedge clk);
        #1;
        check("valid_early", int'(pix_valid), 0);
        @(posedge clk);
        #1;
        check("first_valid", int'(pix_valid), 1);
        gaps = 0;
        repeat (95) begin
            @(posedge clk);
            #1;
            if (!pix_valid) gaps++;
        end
        check("b2b_gaps", gaps, 0);
        @(posedge clk);
        #1;
        check("busy_drop", int'(busy), 0);
        check("reads_96", reads - base, 96);
        wait_idle(0, 50);

        // Random backpressure on two scans.
        repeat (2) begin
            do_tick(int'($urandom_range(0, NA - 1)));
            wait_idle(1, 2000);
        end

        // Tick mid-scan gets queued; no overrun.
        base = ovr_seen;
        do_tick(20);
        repeat (39) @(posedge clk);
        #1;
        do_tick(6);
        wait_idle(0, 500);
        check("ovr_single", ovr_seen - base, 0);

        // Two ticks while one pending: overrun once, newest kept.
        base = ovr_seen;
        do_tick(33);
        repeat (10) @(posedge clk);
        #1;
        do_tick(44);
        repeat (5) @(posedge clk);
        #1;
        do_tick(55);
        wait_idle(1, 2000);
        check("ovr_double", ovr_seen - base, 1);

        // Sink stalled forever: only two reads may be outstanding.
        pix_ready = 1'b0;
        base = reads;
        do_tick(9);
        repeat (20) @(posedge clk);
        #1;
        check("stall_reads", reads - base, 2);
        check("stall_pv", int'(pix_valid), 1);
        check("stall_rd", int'(rd_en), 0);
        pix_ready = 1'b1;
        wait_idle(0, 500);

        // Reset in the middle of a scan.
        base = pops;
        do_tick(77);
        n = 0;
        while ((pops - base) < 50 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("pix50_timeout", int'(n < 500), 1);
        nrst = 1'b0;
        #1;
        check_zero("midreset");
        exp_q.delete();
        m_busy = 0;
        m_pend = 0;
        reads = 0;
        pops = 0;
        prev_stall = 0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (busy || pix_valid || rd_en) bad++;
        end
        check("post_reset_quiet", bad, 0);
        do_tick(78);
        wait_idle(1, 2000);

        // Extreme angles; address holds last issued value.
        do_tick(127);
        wait_idle(0, 500);
        do_tick(0);
        wait_idle(0, 500);
        check("hold_addr", int'({row, angle, color}),
              int'({5'd31, 7'd0, 2'd2}));

        check("queue_empty", exp_q.size(), 0);
        check("overrun_total", ovr_seen, exp_ovr);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
